// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues fetches to instruction memory
// and loads the IF/ID pipeline register. Redirects, flushes and memory waits
// all turn IF/ID into a bubble; a stall freezes both the PC and IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  logic [31:0] pc;
  ifid_t       ifid;
  logic [31:0] cnt;
  logic        fire;

  // A request goes out only when nothing is going to override the fetch.
  assign imem_req  = ~reset & ~stall & ~flush & ~redirect_valid;
  assign imem_addr = pc;
  assign fire      = imem_req & imem_ready;

  assign if_id_pc          = ifid.pc;
  assign if_id_instruction = ifid.instr;
  assign if_id_valid       = ifid.valid;
  assign fetch_count       = cnt;

  // PC / IF/ID / counter update in strict priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      ifid <= BUBBLE;
      cnt  <= 32'h0;
    end else if (redirect_valid) begin
      // Targets are forced word-aligned; the taken branch kills whatever is in IF/ID.
      pc   <= {redirect_pc[31:2], 2'b00};
      ifid <= BUBBLE;
    end else if (flush) begin
      ifid <= BUBBLE;
    end else if (stall) begin
      pc   <= pc;
      ifid <= ifid;
    end else if (fire) begin
      ifid <= '{pc: pc, instr: imem_rdata, valid: 1'b1};
      pc   <= pc + 32'd4;
      cnt  <= cnt + 32'd1;
    end else begin
      // Memory wait: decode sees a bubble while the same PC is re-requested.
      ifid <= BUBBLE;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] rd_drv = 32'h0;
  logic        rd_auto = 1'b1;
  wire  [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, if_id_pc, if_id_instruction, fetch_count;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  // model state
  logic [31:0] m_pc, m_ipc, m_ins, m_cnt;
  logic        m_vld;

  assign imem_rdata = rd_auto ? (imem_addr ^ 32'hA5A5_0000) : rd_drv;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: the architectural effect of one clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ins = NOP; m_vld = 1'b0; m_cnt = 32'h0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_ipc = 32'h0; m_ins = NOP; m_vld = 1'b0;
    end else if (flush) begin
      m_ipc = 32'h0; m_ins = NOP; m_vld = 1'b0;
    end else if (stall) begin
      // nothing moves
    end else if (imem_ready) begin
      m_ipc = m_pc; m_ins = imem_rdata; m_vld = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end else begin
      m_ipc = 32'h0; m_ins = NOP; m_vld = 1'b0;
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_addr",  imem_addr, m_pc);
      chk("m_req",   {31'b0, imem_req},
          {31'b0, ~reset & ~stall & ~flush & ~redirect_valid});
      chk("m_ifpc",  if_id_pc, m_ipc);
      chk("m_instr", if_id_instruction, m_ins);
      chk("m_valid", {31'b0, if_id_valid}, {31'b0, m_vld});
      chk("m_count", fetch_count, m_cnt);
    end
  end

  task automatic setin(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] rp, input logic rdy);
    reset = r; stall = s; flush = f; redirect_valid = rv;
    redirect_pc = rp; imem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ifid(input string n, input logic [31:0] pc, input logic [31:0] ins,
                      input logic v, input logic [31:0] cnt, input logic [31:0] addr);
    chk({n, "_pc"},    if_id_pc, pc);
    chk({n, "_instr"}, if_id_instruction, ins);
    chk({n, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk({n, "_count"}, fetch_count, cnt);
    chk({n, "_addr"},  imem_addr, addr);
  endtask

  initial begin
    // reset
    setin(1, 0, 0, 0, 0, 1);
    #1 chk("rst_req", {31'b0, imem_req}, 32'h0);
    tick(); tick();
    chk_on = 1'b1;
    ifid("rst", 32'h0, NOP, 0, 0, 32'h0);

    // streaming fetches 0,4
    setin(0, 0, 0, 0, 0, 1);
    #1 chk("first_req", {31'b0, imem_req}, 32'h1);
    tick(); ifid("f0", 32'h0, 32'hA5A5_0000, 1, 1, 32'h4);
    tick(); ifid("f4", 32'h4, 32'hA5A5_0004, 1, 2, 32'h8);

    // stall three cycles holding pc=4
    setin(0, 1, 0, 0, 0, 1);
    #1 chk("stall_req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); ifid("stall", 32'h4, 32'hA5A5_0004, 1, 2, 32'h8);
    end

    // memory wait at PC=8
    setin(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); ifid("wait", 32'h0, NOP, 0, 2, 32'h8);
    end
    setin(0, 0, 0, 0, 0, 1);
    tick(); ifid("f8", 32'h8, 32'hA5A5_0008, 1, 3, 32'hC);
    tick(); ifid("fC", 32'hC, 32'hA5A5_000C, 1, 4, 32'h10);

    // flush with IF/ID valid at pc=C
    setin(0, 0, 1, 0, 0, 1);
    #1 chk("flush_req", {31'b0, imem_req}, 32'h0);
    tick(); ifid("flush", 32'h0, NOP, 0, 4, 32'h10);

    // redirect beats stall, target aligned down
    setin(0, 1, 0, 1, 32'h0000_0103, 1);
    tick(); ifid("redir", 32'h0, NOP, 0, 4, 32'h100);
    setin(0, 0, 0, 0, 0, 1);
    tick(); ifid("f100", 32'h100, 32'hA5A5_0100, 1, 5, 32'h104);

    // PC wrap
    setin(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    tick();
    setin(0, 0, 0, 0, 0, 1);
    tick(); ifid("wrapA", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1, 6, 32'h0);
    tick(); ifid("wrapB", 32'h0, 32'hA5A5_0000, 1, 7, 32'h4);

    // reset during a memory wait abandons the fetch
    setin(0, 0, 0, 0, 0, 0);
    tick();
    setin(1, 0, 0, 0, 0, 0);
    tick(); ifid("rstwait", 32'h0, NOP, 0, 0, 32'h0);

    // randomized traffic against the model
    rd_auto = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      setin(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 8),
            $urandom,
            ($urandom_range(0, 99) < 70));
      rd_drv = $urandom;
      tick();
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction word driven for a bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit stall; holds PC and IF/ID register.
REQ-006 flush  input  1  converts IF/ID contents to a bubble on the next edge.
REQ-007 redirect_valid  input  1  branch/jump taken; load redirect_pc into PC.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, equal to current PC.
REQ-011 imem_rdata  input  32  instruction word for imem_addr, valid when imem_ready=1.
REQ-012 imem_ready  input  1  memory completes the requested fetch this cycle.
REQ-013 if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-014 if_id_instruction  output  32  instruction word presented to the decode-stage parser.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 fetch_count  output  32  number of instructions loaded valid into IF/ID since reset.

Function
REQ-017 imem_addr shall equal the PC register combinationally at all times.
REQ-018 imem_req shall be combinational: 1 iff reset=0, stall=0, flush=0 and redirect_valid=0.
REQ-019 A fetch completes in a cycle iff imem_req=1 and imem_ready=1.
REQ-020 Edge-update priority: reset > redirect_valid > flush > stall > fetch complete > memory wait.
REQ-021 redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; regardless of stall or flush.
REQ-022 flush=1, redirect_valid=0: IF/ID <= bubble; PC held.
REQ-023 stall=1, flush=0, redirect_valid=0: PC and IF/ID (pc, instruction, valid) held unchanged.
REQ-024 Fetch complete: IF/ID <= {pc=PC, instruction=imem_rdata, valid=1}; PC <= PC+4 modulo 2^32; fetch_count increments.
REQ-025 imem_req=1 and imem_ready=0 (memory wait): IF/ID <= bubble; PC held.
REQ-026 Bubble: if_id_valid=0, if_id_instruction=NOP_INSTR, if_id_pc=0.
REQ-027 PC wrap: PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-028 fetch_count shall wrap from 32'hFFFF_FFFF to 0 and change only per REQ-024.
REQ-029 Fetch latency: an instruction returned with imem_ready=1 at edge N is visible on if_id_* after edge N.
REQ-030 imem_rdata is ignored in every cycle without a completed fetch.

Reset
REQ-031 reset=1 at an edge: PC <= RESET_PC, IF/ID <= bubble, fetch_count <= 0; overrides all other inputs.
REQ-032 During reset=1, imem_req=0; the first fetch of RESET_PC is requested the first cycle reset=0.
REQ-033 Reset asserted mid-wait (imem_ready=0) abandons the pending fetch; no IF/ID or counter update from it.

Verification
REQ-034 Reset released, imem_ready=1, rdata=addr^32'hA5A5_0000 -> if_id_pc 0,4,8 on consecutive cycles, valid=1, fetch_count 1,2,3.
REQ-035 imem_ready=0 for 2 cycles at PC=8 -> two bubbles (valid=0, instr=32'h13), PC stays 8, then PC=8 loads valid.
REQ-036 stall=1 for 3 cycles with IF/ID holding pc=4 -> imem_req=0, if_id_pc=4 and instruction held, PC unchanged, count unchanged.
REQ-037 redirect_valid=1, redirect_pc=32'h0000_0103, stall=1 same cycle -> next PC=32'h100, IF/ID bubble; next fetch addr 32'h100.
REQ-038 redirect to 32'hFFFF_FFFC then two completed fetches -> if_id_pc FFFF_FFFC then 0000_0000.
REQ-039 flush=1 with IF/ID valid at pc=C -> bubble next cycle, PC held, imem_req=0 during flush cycle.
